// File: rtl/mac_operand_packer.sv
// mac_operand_packer: joins weight/activation streams, prefixes each filter
// packet with a bias beat and emits framed beats through a 2-entry FIFO.
module mac_operand_packer #(
    parameter int DW          = 8,
    parameter int IDW         = 8,
    parameter int UDW         = 1,
    parameter int FILTER_SIZE = 25,
    parameter int BIAS_EN     = 1
) (
    input  logic              clk,
    input  logic              rstn,
    input  logic [DW-1:0]     wt_saxis_tdata,
    input  logic              wt_saxis_tvalid,
    output logic              wt_saxis_tready,
    input  logic [DW-1:0]     act_saxis_tdata,
    input  logic              act_saxis_tvalid,
    output logic              act_saxis_tready,
    input  logic              act_saxis_tlast,
    input  logic [2*DW-1:0]   bias_saxis_tdata,
    input  logic              bias_saxis_tvalid,
    output logic              bias_saxis_tready,
    output logic [2*DW-1:0]   maxis_tdata,
    output logic              maxis_tvalid,
    input  logic              maxis_tready,
    output logic [UDW-1:0]    maxis_tuser,
    output logic              maxis_tlast,
    output logic [IDW-1:0]    maxis_tid,
    output logic              frame_err
);
    localparam int EW = 2*DW + UDW + 1 + IDW;
    localparam logic [15:0] LAST_IDX = 16'(FILTER_SIZE - 1);

    typedef enum logic {BIAS = 1'b0, OPER = 1'b1} state_t;
    localparam state_t INIT = (BIAS_EN != 0) ? BIAS : OPER;

    state_t        state, state_nxt;
    logic [15:0]   elem_cnt;
    logic [IDW-1:0] pkt_id;
    logic          ferr;

    logic [EW-1:0] mem [2];
    logic [1:0]    count;
    logic          head, tail;

    logic          space, is_last;
    logic          bias_hs, oper_hs, push, pop;
    logic [EW-1:0] push_data, head_q;

    assign space   = (count != 2'd2);
    assign is_last = (elem_cnt == LAST_IDX);
    assign bias_hs = bias_saxis_tready & bias_saxis_tvalid;
    // wt ready already includes act valid, so this is the joint handshake
    assign oper_hs = wt_saxis_tready & wt_saxis_tvalid;
    assign push    = bias_hs | oper_hs;
    assign pop     = maxis_tvalid & maxis_tready;

    always_ff @(posedge clk) begin
        if (!rstn) state <= INIT;
        else       state <= state_nxt;
    end

    always_comb begin
        state_nxt = state;
        unique case (state)
            BIAS: if (bias_hs) state_nxt = OPER;
            OPER: if (oper_hs && is_last && BIAS_EN != 0) state_nxt = BIAS;
            default: state_nxt = INIT;
        endcase
    end

    always_comb begin
        bias_saxis_tready = 1'b0;
        wt_saxis_tready   = 1'b0;
        act_saxis_tready  = 1'b0;
        if (rstn) begin
            unique case (state)
                BIAS: bias_saxis_tready = (BIAS_EN != 0) && space;
                OPER: begin
                    wt_saxis_tready  = act_saxis_tvalid & space;
                    act_saxis_tready = wt_saxis_tvalid & space;
                end
                default: ;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (!rstn) begin
            elem_cnt <= '0;
            pkt_id   <= '0;
            ferr     <= 1'b0;
        end else if (oper_hs) begin
            if (act_saxis_tlast != is_last) ferr <= 1'b1;
            if (is_last) begin
                elem_cnt <= '0;
                pkt_id   <= pkt_id + IDW'(1);
            end else begin
                elem_cnt <= elem_cnt + 16'd1;
            end
        end
    end

    always_comb begin
        if (oper_hs)
            push_data = {wt_saxis_tdata, act_saxis_tdata,
                         {UDW{1'b1}}, is_last, pkt_id};
        else
            push_data = {bias_saxis_tdata, {UDW{1'b0}}, 1'b0, pkt_id};
    end

    always_ff @(posedge clk) begin
        if (!rstn) begin
            mem[0] <= '0;
            mem[1] <= '0;
            count  <= '0;
            head   <= 1'b0;
            tail   <= 1'b0;
        end else begin
            if (push) begin
                mem[tail] <= push_data;
                tail      <= ~tail;
            end
            if (pop) head <= ~head;
            count <= count + {1'b0, push} - {1'b0, pop};
        end
    end

    assign head_q       = mem[head];
    assign maxis_tvalid = rstn && (count != 2'd0);
    assign maxis_tdata  = rstn ? head_q[EW-1 -: 2*DW] : '0;
    assign maxis_tuser  = rstn ? head_q[IDW+1 +: UDW] : '0;
    assign maxis_tlast  = rstn & head_q[IDW];
    assign maxis_tid    = rstn ? head_q[IDW-1:0] : '0;
    assign frame_err    = rstn & ferr;
endmodule

// File: tb/tb_mac_operand_packer.sv
// Bench for mac_operand_packer: packet-level model with scoreboard plus
// directed literal checks on ordering, stalls, backpressure, wrap and reset.
module tb_mac_operand_packer;
    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic        rstn;
    logic [7:0]  wt_d, act_d;
    logic        wt_v, act_v, act_l, bias_v, m_rdy;
    logic [15:0] bias_d;
    logic        wt_rdy, act_rdy, bias_rdy, m_vld, m_u, m_l, ferr;
    logic [15:0] m_d;
    logic [1:0]  m_id;

    mac_operand_packer #(.DW(8), .IDW(2), .UDW(1), .FILTER_SIZE(3), .BIAS_EN(1)) dut (
        .clk(clk), .rstn(rstn),
        .wt_saxis_tdata(wt_d), .wt_saxis_tvalid(wt_v), .wt_saxis_tready(wt_rdy),
        .act_saxis_tdata(act_d), .act_saxis_tvalid(act_v), .act_saxis_tready(act_rdy),
        .act_saxis_tlast(act_l),
        .bias_saxis_tdata(bias_d), .bias_saxis_tvalid(bias_v), .bias_saxis_tready(bias_rdy),
        .maxis_tdata(m_d), .maxis_tvalid(m_vld), .maxis_tready(m_rdy),
        .maxis_tuser(m_u), .maxis_tlast(m_l), .maxis_tid(m_id), .frame_err(ferr)
    );

    logic        b_rstn;
    logic [7:0]  b_wt_d, b_act_d;
    logic        b_wt_v, b_act_v, b_act_l, b_bias_v, b_m_rdy;
    logic [15:0] b_bias_d;
    logic        b_wt_rdy, b_act_rdy, b_bias_rdy, b_m_vld, b_m_u, b_m_l, b_ferr;
    logic [15:0] b_m_d;
    logic [1:0]  b_m_id;

    mac_operand_packer #(.DW(8), .IDW(2), .UDW(1), .FILTER_SIZE(3), .BIAS_EN(0)) dut_nb (
        .clk(clk), .rstn(b_rstn),
        .wt_saxis_tdata(b_wt_d), .wt_saxis_tvalid(b_wt_v), .wt_saxis_tready(b_wt_rdy),
        .act_saxis_tdata(b_act_d), .act_saxis_tvalid(b_act_v), .act_saxis_tready(b_act_rdy),
        .act_saxis_tlast(b_act_l),
        .bias_saxis_tdata(b_bias_d), .bias_saxis_tvalid(b_bias_v), .bias_saxis_tready(b_bias_rdy),
        .maxis_tdata(b_m_d), .maxis_tvalid(b_m_vld), .maxis_tready(b_m_rdy),
        .maxis_tuser(b_m_u), .maxis_tlast(b_m_l), .maxis_tid(b_m_id), .frame_err(b_ferr)
    );

    typedef struct {
        logic [15:0] d;
        logic        u;
        logic        l;
        logic [1:0]  id;
        int          cyc;
    } beat_t;

    beat_t       exp_q[$];
    beat_t       got_q[$];
    logic [7:0]  wq[$];
    logic [8:0]  aq[$];
    logic [15:0] bq[$];
    logic [1:0]  m_pkt;

    int n_chk = 0;
    int n_pass = 0;
    int cyc = 0;
    int n_bias_hs = 0;
    int n_oper_hs = 0;
    logic wt_en, act_en;
    logic s_wt_hs, s_act_hs, s_b_hs;

    task automatic check(input string name, input logic [31:0] got, input logic [31:0] want);
        n_chk++;
        if (got === want) n_pass++;
        else $display("FAIL %s: got %0h want %0h", name, got, want);
    endtask

    task automatic add_packet(input logic [15:0] b, input logic [23:0] w,
                              input logic [23:0] a, input logic [2:0] tl);
        beat_t e;
        bq.push_back(b);
        e.d = b; e.u = 1'b0; e.l = 1'b0; e.id = m_pkt; e.cyc = 0;
        exp_q.push_back(e);
        for (int i = 0; i < 3; i++) begin
            wq.push_back(w[8*i +: 8]);
            aq.push_back({tl[i], a[8*i +: 8]});
            e.d = {w[8*i +: 8], a[8*i +: 8]};
            e.u = 1'b1;
            e.l = (i == 2);
            exp_q.push_back(e);
        end
        m_pkt = m_pkt + 2'd1;
    endtask

    task automatic refresh();
        wt_v   = wt_en && wq.size() > 0;
        wt_d   = (wq.size() > 0) ? wq[0] : 8'h00;
        act_v  = act_en && aq.size() > 0;
        {act_l, act_d} = (aq.size() > 0) ? aq[0] : 9'h000;
        bias_v = bq.size() > 0;
        bias_d = (bq.size() > 0) ? bq[0] : 16'h0000;
    endtask

    task automatic sample();
        @(negedge clk);
        s_wt_hs  = wt_v && wt_rdy;
        s_act_hs = act_v && act_rdy;
        s_b_hs   = bias_v && bias_rdy;
    endtask

    task automatic advance();
        @(posedge clk);
        #1;
        if (s_wt_hs && wq.size() > 0) void'(wq.pop_front());
        if (s_act_hs && aq.size() > 0) void'(aq.pop_front());
        if (s_b_hs && bq.size() > 0) void'(bq.pop_front());
        if (s_b_hs) n_bias_hs++;
        if (s_wt_hs) n_oper_hs++;
        refresh();
    endtask

    task automatic step();
        sample();
        advance();
    endtask

    task automatic wait_out(input int n, input int budget);
        int t = 0;
        while (got_q.size() < n && t < budget) begin
            step();
            t++;
        end
        check("out_count", 32'(got_q.size() >= n), 32'd1);
    endtask

    task automatic wait_oper(input int n, input int budget);
        int t = 0;
        while (n_oper_hs < n && t < budget) begin
            step();
            t++;
        end
        check("oper_count", 32'(n_oper_hs >= n), 32'd1);
    endtask

    // Scoreboard, stability and frame-error model, evaluated every cycle
    logic        exp_ferr = 1'b0;
    int          k = 0;
    logic        prev_stall = 1'b0;
    logic [19:0] prev_beat = '0;
    always @(negedge clk) begin
        beat_t e, g;
        logic  ohs;
        cyc++;
        if (!rstn) begin
            exp_ferr = 1'b0;
            k = 0;
        end
        check("frame_err", 32'(ferr), 32'(exp_ferr));
        if ((wt_v && wt_rdy) || (act_v && act_rdy))
            check("join", {30'd0, wt_v && wt_rdy, act_v && act_rdy}, 32'd3);
        ohs = rstn && wt_v && wt_rdy && act_v && act_rdy;
        if (ohs) begin
            if (act_l != (k == 2)) exp_ferr = 1'b1;
            k = (k == 2) ? 0 : k + 1;
        end
        if (prev_stall && rstn)
            check("stable", {11'd0, m_vld, m_d, m_u, m_l, m_id}, {11'd0, 1'b1, prev_beat});
        if (m_vld && m_rdy) begin
            if (exp_q.size() == 0) begin
                check("unexpected_beat", 32'(m_d), 32'hFFFF_FFFF);
            end else begin
                e = exp_q.pop_front();
                check("beat", {12'd0, m_d, m_u, m_l, m_id}, {12'd0, e.d, e.u, e.l, e.id});
            end
            g.d = m_d; g.u = m_u; g.l = m_l; g.id = m_id; g.cyc = cyc;
            got_q.push_back(g);
        end
        prev_stall = m_vld && !m_rdy;
        prev_beat  = {m_d, m_u, m_l, m_id};
    end

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout want finish");
        $fatal(1);
    end

    initial begin
        int base, t, n0;
        rstn = 1'b0; m_rdy = 1'b1; wt_en = 1'b1; act_en = 1'b1; m_pkt = 2'd0;
        b_rstn = 1'b0; b_wt_d = 8'h11; b_act_d = 8'h22; b_wt_v = 1'b1;
        b_act_v = 1'b1; b_act_l = 1'b0; b_bias_d = 16'hBEEF; b_bias_v = 1'b1;
        b_m_rdy = 1'b1;
        s_wt_hs = 0; s_act_hs = 0; s_b_hs = 0;

        // Reset with valid inputs pending: everything held at 0
        add_packet(16'h0105, 24'h030201, 24'h060504, 3'b100);
        add_packet(16'h7FF0, 24'hC0B0A0, 24'h0F0E0D, 3'b100);
        refresh();
        repeat (2) step();
        sample();
        check("reset_outs", {7'd0, wt_rdy, act_rdy, bias_rdy, m_vld, m_d, m_u, m_l, m_id, ferr}, 32'd0);
        advance();
        rstn = 1'b1;
        sample();
        check("release_outs", {8'd0, m_vld, m_d, m_u, m_l, m_id, ferr}, 32'd0);
        check("release_bias_rdy", {30'd0, bias_rdy, wt_rdy}, 32'd2);
        advance();
        step();
        check("latency", 32'(got_q.size()), 32'd1);

        // Ordering and back-to-back throughput
        wait_out(8, 40);
        check("p0_bias", {12'd0, got_q[0].d, got_q[0].u, got_q[0].l, got_q[0].id}, {12'd0, 16'h0105, 1'b0, 1'b0, 2'd0});
        check("p0_e0", {12'd0, got_q[1].d, got_q[1].u, got_q[1].l, got_q[1].id}, {12'd0, 16'h0104, 1'b1, 1'b0, 2'd0});
        check("p0_e1", {12'd0, got_q[2].d, got_q[2].u, got_q[2].l, got_q[2].id}, {12'd0, 16'h0205, 1'b1, 1'b0, 2'd0});
        check("p0_e2", {12'd0, got_q[3].d, got_q[3].u, got_q[3].l, got_q[3].id}, {12'd0, 16'h0306, 1'b1, 1'b1, 2'd0});
        check("p1_bias", {12'd0, got_q[4].d, got_q[4].u, got_q[4].l, got_q[4].id}, {12'd0, 16'h7FF0, 1'b0, 1'b0, 2'd1});
        check("back_to_back", 32'(got_q[7].cyc - got_q[0].cyc), 32'd7);

        // Join stall: activations withheld for 4 cycles after the bias beat
        act_en = 1'b0;
        add_packet(16'h8001, 24'h55807F, 24'hAAFF01, 3'b100);
        refresh();
        base = n_bias_hs; t = 0;
        while (n_bias_hs == base && t < 50) begin step(); t++; end
        check("join_bias_hs", 32'(n_bias_hs - base), 32'd1);
        base = n_oper_hs;
        repeat (4) begin
            sample();
            check("join_stall", {30'd0, wt_v, wt_rdy}, 32'd2);
            advance();
        end
        check("join_no_hs", 32'(n_oper_hs - base), 32'd0);
        act_en = 1'b1;
        refresh();
        wait_out(12, 40);

        // Backpressure: exactly two beats enter, then all readies drop
        m_rdy = 1'b0;
        add_packet(16'hFFFF, 24'h070809, 24'hFDFEFF, 3'b100);
        refresh();
        base = n_bias_hs + n_oper_hs;
        repeat (10) step();
        check("bp_accepted", 32'(n_bias_hs + n_oper_hs - base), 32'd2);
        sample();
        check("bp_readies", {28'd0, m_vld, bias_rdy, wt_rdy, act_rdy}, 32'h8);
        advance();
        m_rdy = 1'b1;
        sample();
        check("bp_pre_pop", {29'd0, bias_rdy, wt_rdy, act_rdy}, 32'd0);
        advance();
        sample();
        check("bp_reassert", {31'd0, wt_rdy}, 32'd1);
        advance();
        wait_out(16, 40);

        // tid wrap at 2^IDW
        add_packet(16'h2222, 24'h333231, 24'h434241, 3'b100);
        refresh();
        wait_out(20, 40);
        check("tid_wrap", {22'd0, got_q[0].id, got_q[4].id, got_q[8].id, got_q[12].id, got_q[16].id},
              {22'd0, 2'd0, 2'd1, 2'd2, 2'd3, 2'd0});
        check("wrap_bias_user", {29'd0, got_q[16].u, got_q[16].l, got_q[19].l}, 32'd1);

        // Framing: tlast on element 1 of 3
        sample();
        check("ferr_before", {31'd0, ferr}, 32'd0);
        advance();
        add_packet(16'h0A0B, 24'h030201, 24'h030201, 3'b110);
        refresh();
        wait_oper(n_oper_hs + 2, 40);
        sample();
        check("ferr_rise", {31'd0, ferr}, 32'd1);
        advance();
        wait_out(24, 40);
        sample();
        check("ferr_sticky", {31'd0, ferr}, 32'd1);
        advance();

        // Reset mid-packet after two operand beats
        add_packet(16'h5A5A, 24'h262524, 24'h363534, 3'b100);
        refresh();
        wait_oper(n_oper_hs + 2, 40);
        rstn = 1'b0;
        wq.delete(); aq.delete(); bq.delete(); exp_q.delete();
        m_pkt = 2'd0;
        refresh();
        add_packet(16'h1234, 24'h0C0B0A, 24'h1C1B1A, 3'b100);
        refresh();
        repeat (2) begin
            sample();
            check("mid_reset_outs", {7'd0, wt_rdy, act_rdy, bias_rdy, m_vld, m_d, m_u, m_l, m_id, ferr}, 32'd0);
            advance();
        end
        rstn = 1'b1;
        n0 = got_q.size();
        wait_out(n0 + 4, 40);
        check("after_reset", {12'd0, got_q[n0].d, got_q[n0].u, got_q[n0].l, got_q[n0].id},
              {12'd0, 16'h1234, 1'b0, 1'b0, 2'd0});

        // BIAS_EN=0 instance: operand beats only, reset mid-packet
        sample();
        check("nb_reset", {7'd0, b_wt_rdy, b_act_rdy, b_bias_rdy, b_m_vld, b_m_d, b_m_u, b_m_l, b_m_id, b_ferr}, 32'd0);
        advance();
        b_rstn = 1'b1;
        sample();
        check("nb_readies", {28'd0, b_wt_rdy, b_act_rdy, b_bias_rdy, b_m_vld}, 32'hC);
        advance();
        b_wt_d = 8'h13; b_act_d = 8'h24;
        sample();
        check("nb_beat0", {11'd0, b_m_vld, b_m_d, b_m_u, b_m_l, b_m_id}, {11'd0, 1'b1, 16'h1122, 1'b1, 1'b0, 2'd0});
        check("nb_bias_rdy", {31'd0, b_bias_rdy}, 32'd0);
        advance();
        b_rstn = 1'b0;
        repeat (2) begin
            sample();
            check("nb_mid_reset", {7'd0, b_wt_rdy, b_act_rdy, b_bias_rdy, b_m_vld, b_m_d, b_m_u, b_m_l, b_m_id, b_ferr}, 32'd0);
            advance();
        end
        b_rstn = 1'b1;
        b_wt_d = 8'h33; b_act_d = 8'h44;
        sample();
        check("nb_rdy_again", {31'd0, b_wt_rdy}, 32'd1);
        advance();
        b_wt_v = 1'b0; b_act_v = 1'b0;
        sample();
        check("nb_after_reset", {11'd0, b_m_vld, b_m_d, b_m_u, b_m_l, b_m_id}, {11'd0, 1'b1, 16'h3344, 1'b1, 1'b0, 2'd0});
        advance();

        repeat (3) step();
        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end
endmodule
